// File: rtl/eh2_lsu_trig_hit_ctl.sv
// eh2_lsu_trig_hit_ctl
// Collects qualified LSU trigger hits into one small FIFO per thread and
// presents them one at a time to a consumer through a valid/ack handshake,
// with round-robin arbitration between threads.
// Build option: define RV_LSU_TRIG_CHAIN_EN to apply trigger_chain pairing
// to the raw match vector; left undefined, the raw vector is used as-is.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing presented, trig_hit_valid low
// PRESENT | head of thread tid_q presented, outputs held until ack/flush

module eh2_lsu_trig_hit_ctl #(
  parameter int NUM_THREADS = 2,
  parameter int DEPTH       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  lsu_trigger_match_dc4,
  input  logic                        lsu_trig_valid_dc4,
  input  logic                        lsu_trig_tid_dc4,
  input  logic [NUM_THREADS-1:0][1:0] trigger_chain,
  input  logic [NUM_THREADS-1:0]      flush,
  input  logic                        trig_hit_ack,
  output logic                        trig_hit_valid,
  output logic                        trig_hit_tid,
  output logic [3:0]                  trig_hit_vec,
  output logic [NUM_THREADS-1:0]      trig_busy,
  output logic [NUM_THREADS-1:0]      trig_overflow
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e                        state_q;
  logic                          valid_q;
  logic                          tid_q;
  logic [3:0]                    vec_q;
  logic                          rr_q;

  logic [NUM_THREADS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_THREADS-1:0][PW-1:0] rd_q, rd_d;
  logic [NUM_THREADS-1:0][PW-1:0] wr_q, wr_d;
  logic [3:0]                     mem_q [NUM_THREADS][DEPTH];
  logic [NUM_THREADS-1:0]         ovf_q;

  logic                   enq_tid;
  logic [3:0]             enq_qual;
  logic                   flush_enq;
  logic                   enq_ok;
  logic [NUM_THREADS-1:0] push, pop, full, wr_en, drop, avail;
  logic [3:0]             head_vec [NUM_THREADS];
  logic [CW-1:0]          remain;
  logic                   pop_any, any_avail;
  logic                   next_tid, pri, pri_avail, sel;
  logic [3:0]             sel_vec;
  logic                   flush_pres;

  // A single-thread build has no thread select; everything lands on thread 0.
  assign enq_tid = (NUM_THREADS == 1) ? 1'b0 : lsu_trig_tid_dc4;

`ifdef RV_LSU_TRIG_CHAIN_EN
  logic [1:0] chain_sel;

  // Chained pairs report only when both members match, otherwise neither.
  always_comb begin
    enq_qual  = lsu_trigger_match_dc4;
    chain_sel = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (enq_tid == 1'(t)) chain_sel = trigger_chain[t];
    end
    for (int k = 0; k < 2; k++) begin
      if (chain_sel[k]) begin
        enq_qual[2*k]   = lsu_trigger_match_dc4[2*k] & lsu_trigger_match_dc4[2*k+1];
        enq_qual[2*k+1] = lsu_trigger_match_dc4[2*k] & lsu_trigger_match_dc4[2*k+1];
      end
    end
  end
`else
  logic unused_chain;
  assign unused_chain = ^trigger_chain;

  // Without chaining the raw match vector is reported directly.
  always_comb begin
    enq_qual = lsu_trigger_match_dc4;
  end
`endif

  // A hit on a thread being flushed in the same cycle is discarded.
  always_comb begin
    flush_enq = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (enq_tid == 1'(t) && flush[t]) flush_enq = 1'b1;
    end
  end

  assign enq_ok = lsu_trig_valid_dc4 && (enq_qual != 4'b0000) && !flush_enq;

  // Per-thread queue bookkeeping and the head each queue will show next cycle.
  always_comb begin
    push   = '0;
    pop    = '0;
    full   = '0;
    wr_en  = '0;
    drop   = '0;
    avail  = '0;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    remain = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      head_vec[t] = '0;
    end
    for (int t = 0; t < NUM_THREADS; t++) begin
      full[t]  = (cnt_q[t] == CW'(DEPTH));
      push[t]  = enq_ok && (enq_tid == 1'(t));
      pop[t]   = (state_q == PRESENT) && trig_hit_ack && (tid_q == 1'(t)) && !flush[t];
      wr_en[t] = push[t] && (!full[t] || pop[t]);
      drop[t]  = push[t] && full[t] && !pop[t];
      if (flush[t]) begin
        cnt_d[t] = '0;
        rd_d[t]  = '0;
        wr_d[t]  = '0;
      end else begin
        cnt_d[t] = cnt_q[t] + CW'(wr_en[t]) - CW'(pop[t]);
        rd_d[t]  = rd_q[t] + PW'(pop[t]);
        wr_d[t]  = wr_q[t] + PW'(wr_en[t]);
      end
      // When the queue drains to nothing this edge, the only possible head is
      // the entry being written now, which is not yet visible in mem_q.
      remain      = cnt_q[t] - CW'(pop[t]);
      head_vec[t] = (remain == '0) ? enq_qual : mem_q[t][rd_d[t]];
      avail[t]    = (cnt_d[t] != '0);
    end
  end

  assign pop_any   = |pop;
  assign any_avail = |avail;
  assign next_tid  = (NUM_THREADS == 2) ? ~tid_q : 1'b0;

  // Round-robin pick; an ack in this cycle already moves priority past tid_q.
  always_comb begin
    pri       = pop_any ? next_tid : rr_q;
    pri_avail = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (pri == 1'(t) && avail[t]) pri_avail = 1'b1;
    end
    if (NUM_THREADS == 1) begin
      sel = 1'b0;
    end else begin
      sel = pri_avail ? pri : ~pri;
    end
    sel_vec = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (sel == 1'(t)) sel_vec = head_vec[t];
    end
  end

  // Flushing the presented thread withdraws the presentation.
  always_comb begin
    flush_pres = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (tid_q == 1'(t) && flush[t]) flush_pres = 1'b1;
    end
  end

  // Queue storage, pointers, counts and sticky overflow flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      ovf_q <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_q[t][d] <= '0;
        end
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        cnt_q[t] <= cnt_d[t];
        rd_q[t]  <= rd_d[t];
        wr_q[t]  <= wr_d[t];
        if (wr_en[t]) mem_q[t][wr_q[t]] <= enq_qual;
        if (drop[t])  ovf_q[t] <= 1'b1;
      end
    end
  end

  // Output FSM with registered presentation and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      tid_q   <= 1'b0;
      vec_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_avail) begin
            state_q <= PRESENT;
            valid_q <= 1'b1;
            tid_q   <= sel;
            vec_q   <= sel_vec;
          end
        end
        PRESENT: begin
          if (flush_pres) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            tid_q   <= 1'b0;
            vec_q   <= '0;
          end else if (trig_hit_ack) begin
            rr_q <= next_tid;
            if (any_avail) begin
              state_q <= PRESENT;
              valid_q <= 1'b1;
              tid_q   <= sel;
              vec_q   <= sel_vec;
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              tid_q   <= 1'b0;
              vec_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          tid_q   <= 1'b0;
          vec_q   <= '0;
        end
      endcase
    end
  end

  assign trig_hit_valid = valid_q;
  assign trig_hit_tid   = tid_q;
  assign trig_hit_vec   = vec_q;
  assign trig_overflow  = ovf_q;

  // A thread stalls exactly while its queue holds DEPTH entries.
  always_comb begin
    trig_busy = full;
  end

endmodule
